// File: rtl/vga_line_fetch.sv
// Scanline prefetch: streams one framebuffer line per HSYNC into a ping-pong
// line buffer over a single-outstanding req/ack port, serving the other bank.
module vga_line_fetch #(
    parameter int unsigned HOR_PXL     = 800,
    parameter int unsigned VER_PXL     = 600,
    parameter logic [31:0] FB_BASE     = 32'h0000_0000,
    parameter logic [31:0] LINE_STRIDE = 32'd3200
) (
    input  logic        sys_pclk,
    input  logic        rst,
    input  logic        frame_int,
    input  logic        buffill_int,
    input  logic [9:0]  colbuf_addr,
    output logic [31:0] colbuf_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] underrun_cnt
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DONE,
        S_DRAIN
    } state_t;

    localparam logic [9:0]  LAST_WORD = 10'(HOR_PXL - 1);
    localparam logic [10:0] LINES     = 11'(VER_PXL);

    state_t      state_q, state_d;
    logic [31:0] line_base_q, line_base_d;
    logic [9:0]  line_q, line_d;
    logic [9:0]  word_q, word_d;
    logic        disp_bank_q, disp_bank_d;
    logic        frame_dly_q, hsync_dly_q;
    logic [15:0] underrun_cnt_q, underrun_cnt_d;
    logic        underrun_q, underrun_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] colbuf_data_q, colbuf_data_d;
    logic        frame_rise, hsync_rise, fill_we, restart;

    logic [31:0] ram [0:2047];

    assign frame_rise = frame_int & ~frame_dly_q;
    assign hsync_rise = buffill_int & ~hsync_dly_q;
    assign fill_we    = (state_q == S_FETCH) & mem_ack;

    always_comb begin
        state_d        = state_q;
        line_base_d    = line_base_q;
        line_d         = line_q;
        word_d         = word_q;
        disp_bank_d    = disp_bank_q;
        underrun_d     = 1'b0;
        restart        = 1'b0;
        underrun_cnt_d = frame_rise ? 16'd0 : underrun_cnt_q;
        unique case (state_q)
            S_IDLE: restart = frame_rise;
            S_FETCH: begin
                if (frame_rise) begin
                    // an ack in this very cycle leaves nothing outstanding
                    if (mem_ack) restart = 1'b1;
                    else         state_d = S_DRAIN;
                end else begin
                    if (hsync_rise) begin
                        underrun_d = 1'b1;
                        if (underrun_cnt_q != 16'hFFFF)
                            underrun_cnt_d = underrun_cnt_q + 16'd1;
                    end
                    if (mem_ack) begin
                        word_d = word_q + 10'd1;
                        if (word_q == LAST_WORD) begin
                            word_d  = '0;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                if (frame_rise) begin
                    restart = 1'b1;
                end else if (hsync_rise) begin
                    disp_bank_d = ~disp_bank_q;
                    line_d      = line_q + 10'd1;
                    if ({1'b0, line_q} + 11'd1 < LINES) begin
                        line_base_d = line_base_q + LINE_STRIDE;
                        word_d      = '0;
                        state_d     = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: restart = mem_ack;
            default: state_d = S_IDLE;
        endcase
        if (restart) begin
            line_base_d = FB_BASE;
            line_d      = '0;
            word_d      = '0;
            state_d     = S_FETCH;
        end
        mem_req_d  = (state_d == S_FETCH) || (state_d == S_DRAIN);
        mem_addr_d = mem_req_d ? line_base_d + {20'd0, word_d, 2'b00} : 32'd0;
        colbuf_data_d = (colbuf_addr <= LAST_WORD) ?
                        ram[{disp_bank_q, colbuf_addr}] : 32'd0;
    end

    always_ff @(posedge sys_pclk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            line_base_q    <= FB_BASE;
            line_q         <= '0;
            word_q         <= '0;
            disp_bank_q    <= 1'b0;
            frame_dly_q    <= 1'b0;
            hsync_dly_q    <= 1'b0;
            underrun_cnt_q <= '0;
            underrun_q     <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            colbuf_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            line_base_q    <= line_base_d;
            line_q         <= line_d;
            word_q         <= word_d;
            disp_bank_q    <= disp_bank_d;
            frame_dly_q    <= frame_int;
            hsync_dly_q    <= buffill_int;
            underrun_cnt_q <= underrun_cnt_d;
            underrun_q     <= underrun_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            colbuf_data_q  <= colbuf_data_d;
        end
    end

    // fill side always writes the bank the display is not reading
    always_ff @(posedge sys_pclk) begin
        if (fill_we)
            ram[{~disp_bank_q, word_q}] <= mem_rdata;
    end

    assign colbuf_data  = colbuf_data_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign busy         = mem_req_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;
endmodule

// File: doc/vga_line_fetch.md
# vga_line_fetch

Scanline prefetch engine that sits directly upstream of the VGA timing/output interface. It streams one 800-pixel line of 32-bit framebuffer words from system RAM over a single-outstanding req/ack read port into a ping-pong line buffer. It swaps banks on each line-start event and serves the display bank to the VGA side through a `colbuf_addr`/`colbuf_data` read port. It also reports underruns when a line is not ready in time.

## Interface
- `HOR_PXL`, 800: words (pixels) per line; must be ≤1024.
- `VER_PXL`, 600: lines per frame.
- `FB_BASE`, 32'h0000_0000: byte address of line 0, word 0.
- `LINE_STRIDE`, 3200: byte distance between line starts.
- Clock and reset: one clock; reset is synchronous and active-high.
- `sys_pclk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `frame_int` in 1: VSYNC level from the VGA interface; its rising edge starts a frame.
- `buffill_int` in 1: HSYNC level from the VGA interface; its rising edge is a line-start event.
- `colbuf_addr` in 10: word index into the display bank.
- `colbuf_data` out 32: display-bank word, registered.
- `mem_req` out 1: read request.
- `mem_addr` out 32: byte address, word aligned (bits [1:0]=0).
- `mem_ack` in 1: read acknowledge; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: read data.
- `busy` out 1: a fetch is in progress (FETCH or DRAIN).
- `underrun` out 1: one-cycle pulse; a line-start event arrived before the fill line completed.
- `underrun_cnt` out 16: saturating underrun count; cleared on each frame start.

## Operation
- Storage: 2×1024×32 RAM banks. `disp_bank` selects the bank the VGA side reads; the other bank is the fill bank.
- Edge detect: each of `frame_int` and `buffill_int` has a 1-FF delay; `rise = in & ~dly`.
- Address generation: `line_base` register, set to `FB_BASE` on frame start and incremented by `LINE_STRIDE` per started line. `mem_addr = line_base + (word<<2)`, mod 2^32. No multiplier.
- State machine:
  - IDLE:
    - frame rise → load `line_base=FB_BASE`, `line=0`, `word=0`, clear `underrun_cnt` → FETCH.
  - FETCH:
    - `mem_req=1` with `mem_addr` held stable until ack.
    - On ack: write `mem_rdata` to fill bank[`word`] and increment `word`.
    - If `word==HOR_PXL-1` at ack → DONE. Otherwise `mem_req` stays high next cycle with the next address.
  - DONE:
    - Line ready; waiting for a line-start event.
    - hsync rise → toggle `disp_bank`, `line++`.
    - If `line+1<VER_PXL`: `line_base+=LINE_STRIDE`, `word=0`, → FETCH. Otherwise → IDLE.
  - DRAIN:
    - Abort with a request outstanding. `mem_req` stays high until ack; the ack data is discarded.
    - Then restart line 0, as on a frame rise from IDLE → FETCH.
- hsync rise while in FETCH:
  - Pulse `underrun` and increment `underrun_cnt` (saturates at 16'hFFFF).
  - No bank swap; the fetch continues and the display keeps the old bank.
  - The late line swaps on the next hsync rise.
- frame rise in FETCH → DRAIN. frame rise in DONE or IDLE → restart line 0 immediately.
- Simultaneous frame rise and hsync rise: frame wins; no swap, no underrun.
- Read port:
  - `colbuf_data <= (colbuf_addr<HOR_PXL) ? disp_bank[colbuf_addr] : 0`.
  - Reading and filling always target different banks, so there is no read/write collision.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, `disp_bank=0`, `line=0`, `word=0`, `line_base=FB_BASE`, edge-detect FFs 0.
  - Reset mid-transfer drops `mem_req` the next cycle. The memory side must tolerate the abandoned request.
- Clocking: `colbuf_data` latency is 1 `sys_pclk` from `colbuf_addr`.
- Edge-detect latency: an input rise at edge N is acted on at edge N+1. The first `mem_req` is high after edge N+1.
- Throughput: with `mem_ack` tied high, one word per cycle, so a line takes `HOR_PXL` cycles of `mem_req`.
- `underrun` is a single-cycle pulse per offending hsync rise. `underrun_cnt` updates in the same cycle.
- `busy=1` exactly while in FETCH or DRAIN.

## Test plan
- Reset then frame rise, `mem_ack=1`, `mem_rdata=addr` → addresses 0,4,…,3196 in 800 consecutive cycles, then DONE with `busy=0`.
- Frame rise, line 0 filled, then hsync rise → bank swap; `colbuf_addr=5` gives `colbuf_data=20` one cycle later; line 1 fetch starts at `mem_addr=3200`; `colbuf_addr=900` gives 0.
- Ack only every 4th cycle, hsync rise at word 300 → `underrun` pulses once, `underrun_cnt=1`, no swap; the next hsync after DONE swaps.
- Frame rise in FETCH with `mem_ack` held low 5 cycles → `mem_req` and `mem_addr` stay stable, the acked word is discarded, and a new fetch starts at `FB_BASE`; `underrun_cnt` reads 0.
- Run 600 lines → after the 600th hsync swap the state is IDLE, `mem_req=0`, and further hsync rises cause no fetch and no underrun.
- Frame rise and hsync rise in the same cycle in DONE → no swap; restart at line 0. Assert `rst` mid-FETCH → all outputs 0 next cycle.
